// File: rtl/dmaarb_if.sv
// Requester-side and Unibus-side signals of the NPR arbiter.
// The arbiter holds the master modport; the bench/driver layer holds slave.
interface dmaarb_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    req;
  logic [18*NREQ-1:0] reqaddr;
  logic [16*NREQ-1:0] reqwdata;
  logic [2*NREQ-1:0]  reqctl;
  logic [NREQ-1:0]    ack;
  logic               err;
  logic [15:0]        rdata;
  logic               busy;

  logic               npr_out_h;
  logic               npg_in_h;
  logic               sack_out_h;
  logic               bbsy_in_h;
  logic               bbsy_out_h;
  logic [17:0]        a_out_h;
  logic [1:0]         c_out_h;
  logic [15:0]        d_out_h;
  logic               msyn_out_h;
  logic               ssyn_in_h;
  logic [15:0]        d_in_h;
  logic               init_in_h;

  modport master (
    input  req, reqaddr, reqwdata, reqctl,
    input  npg_in_h, bbsy_in_h, ssyn_in_h, d_in_h, init_in_h,
    output ack, err, rdata, busy,
    output npr_out_h, sack_out_h, bbsy_out_h, a_out_h, c_out_h, d_out_h, msyn_out_h
  );

  modport slave (
    output req, reqaddr, reqwdata, reqctl,
    output npg_in_h, bbsy_in_h, ssyn_in_h, d_in_h, init_in_h,
    input  ack, err, rdata, busy,
    input  npr_out_h, sack_out_h, bbsy_out_h, a_out_h, c_out_h, d_out_h, msyn_out_h
  );
endinterface

// File: rtl/dmaarb.sv
// Unibus NPR master: round-robin selection among NREQ single-word requesters,
// then the NPR/SACK/BBSY/MSYN/SSYN handshake with an SSYN timeout (NXM).
module dmaarb #(
  parameter int         NREQ    = 4,
  parameter logic [7:0] TIMEOUT = 8'd200,
  parameter logic [3:0] DESKEW  = 4'd3
) (
  input  logic CLOCK,
  input  logic RESET,
  dmaarb_if.master bus
);
  localparam int         IW       = (NREQ > 2) ? 2 : 1;
  localparam logic [7:0] DESKEW_C = {4'd0, DESKEW};

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_SACK, S_BUS, S_MSYN, S_END} state_t;

  state_t          r_state, w_next;
  logic [IW-1:0]   r_ptr, r_idx, w_win;
  logic            w_found;
  logic [17:0]     r_addr;
  logic [1:0]      r_ctl;
  logic [15:0]     r_wdata, r_rdata;
  logic [7:0]      r_cnt;
  logic            r_tmo, r_err;
  logic [NREQ-1:0] r_ack;
  logic            w_drive, w_tmo_hit, w_clr;

  assign w_clr     = RESET || bus.init_in_h;
  assign w_tmo_hit = (r_cnt == TIMEOUT - 8'd1);

  // Round-robin scan begins one past the last winner
  always_comb begin
    int j;
    w_found = 1'b0;
    w_win   = '0;
    j       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(r_ptr) + k) % NREQ;
      if (!w_found && bus.req[j]) begin
        w_found = 1'b1;
        w_win   = IW'(j);
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_found) w_next = S_REQ;
      S_REQ:  if (bus.npg_in_h) w_next = S_SACK;
      S_SACK: if (!bus.npg_in_h && !bus.bbsy_in_h && !bus.ssyn_in_h) w_next = S_BUS;
      S_BUS:  if (r_cnt == DESKEW_C - 8'd1) w_next = S_MSYN;
      S_MSYN: if (bus.ssyn_in_h || w_tmo_hit) w_next = S_END;
      S_END:  if (!bus.ssyn_in_h) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // r_cnt restarts on every state change; it times both deskew and SSYN wait
  always_ff @(posedge CLOCK) begin
    if (w_clr) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_ack   <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ack   <= '0;
      r_err   <= 1'b0;
      if (w_next != r_state) r_cnt <= '0;
      else if (r_cnt != TIMEOUT) r_cnt <= r_cnt + 8'd1;
      if (r_state == S_MSYN) begin
        if (bus.ssyn_in_h) r_tmo <= 1'b0;
        else if (w_tmo_hit) r_tmo <= 1'b1;
      end
      if (r_state == S_END && !bus.ssyn_in_h) begin
        r_ack[r_idx] <= 1'b1;
        r_err        <= r_tmo;
        r_ptr        <= r_idx;
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) r_rdata <= '0;
    else if (!bus.init_in_h && r_state == S_MSYN && bus.ssyn_in_h && r_ctl == 2'b00)
      r_rdata <= bus.d_in_h;
  end

  always_ff @(posedge CLOCK) begin
    if (r_state == S_IDLE && w_found) begin
      r_idx   <= w_win;
      r_addr  <= bus.reqaddr[18*int'(w_win) +: 18];
      r_wdata <= bus.reqwdata[16*int'(w_win) +: 16];
      r_ctl   <= bus.reqctl[2*int'(w_win) +: 2];
    end
  end

  assign w_drive        = (r_state == S_BUS) || (r_state == S_MSYN) || (r_state == S_END);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.npr_out_h  = (r_state == S_REQ);
  assign bus.sack_out_h = (r_state == S_SACK);
  assign bus.bbsy_out_h = w_drive;
  assign bus.msyn_out_h = (r_state == S_MSYN);
  assign bus.a_out_h    = w_drive ? r_addr : '0;
  assign bus.c_out_h    = w_drive ? r_ctl : '0;
  assign bus.d_out_h    = (w_drive && r_ctl[1]) ? r_wdata : '0;
  assign bus.ack        = r_ack;
  assign bus.err        = r_err;
  assign bus.rdata      = r_rdata;
endmodule

// File: doc/dmaarb.md
# dmaarb

Unibus NPR (DMA) master arbiter and cycle sequencer shared by the disk/tape controller blocks and ARM-side DMA helpers. Accepts single-word transfer requests from up to four requesters, selects one round-robin, and runs the full NPR/SACK/BBSY/MSYN/SSYN master handshake for it. Returns read data, or flags a non-existent-memory timeout. Sits between the device controllers and the FPGA's Unibus driver layer.

## Interface
- NREQ, 4: number of requesters, 2..4.
- TIMEOUT, 8'd200: CLOCK cycles to wait for SSYN before declaring NXM.
- DESKEW, 4'd3: CLOCK cycles between driving address/control/data and asserting MSYN.

- CLOCK  in  1  system clock; all logic on posedge.
- RESET  in  1  synchronous, active-high.
- req  in  NREQ  per-requester transfer request; level; held until its ack.
- reqaddr  in  18*NREQ  per-requester bus address; requester i uses bits [18i+17:18i].
- reqwdata  in  16*NREQ  per-requester write data.
- reqctl  in  2*NREQ  per-requester Unibus C lines (00 DATI, 10 DATO, 11 DATOB).
- ack  out  NREQ  one-cycle completion pulse to the served requester.
- err  out  1  valid with ack: 1 = SSYN timeout (NXM).
- rdata  out  16  DATI data; valid with ack; held until the next ack.
- busy  out  1  a cycle is in progress (state != IDLE).
- npr_out_h  out  1  NPR bus request.
- npg_in_h  in  1  NPR grant.
- sack_out_h  out  1  selection acknowledge.
- bbsy_in_h  in  1  bus busy, as seen from the bus.
- bbsy_out_h  out  1  bus busy, driven by this block.
- a_out_h  out  18  address.
- c_out_h  out  2  control.
- d_out_h  out  16  write data.
- msyn_out_h  out  1  master sync.
- ssyn_in_h  in  1  slave sync.
- d_in_h  in  16  bus data.
- init_in_h  in  1  bus INIT.

## Operation
- Reset (RESET or init_in_h): state IDLE, round-robin pointer 0. All outputs 0 except rdata, which RESET clears and init_in_h leaves unchanged.
- IDLE: scan req starting at pointer+1 mod NREQ. The first asserted requester wins. Latch its index, address, ctl and wdata. Go to REQ. Later changes to the requester's inputs are ignored until its ack.
- REQ: npr_out_h=1. On npg_in_h=1, go to SACK.
- SACK: sack_out_h=1, npr_out_h=0. Wait until npg_in_h=0, bbsy_in_h=0 and ssyn_in_h=0, then go to BUS.
- BUS: bbsy_out_h=1, sack_out_h=0. Drive a_out_h and c_out_h. Drive d_out_h with wdata when c[1]=1, else 0. Count DESKEW cycles, then go to MSYN.
- MSYN: msyn_out_h=1.
  - On ssyn_in_h=1: latch d_in_h into rdata if DATI, clear the timeout flag, go to END.
  - If the timer reaches TIMEOUT first: set the timeout flag, go to END.
- END: msyn_out_h=0. Wait for ssyn_in_h=0. Then in one cycle: pulse ack[idx], drive err=timeout flag, drop bbsy_out_h, zero a/c/d, set pointer=idx, go to IDLE.
- rdata is not updated on DATO, DATOB or a timeout.
- The bus is released after every word. There are no back-to-back holds.
- A requester dropping req mid-cycle does not abort the cycle; it still gets ack.
- init_in_h mid-cycle: immediate return to IDLE, no ack. Requesters must reissue.

## Timing
- IDLE to npr_out_h: 1 cycle after req is seen.
- npg_in_h to sack_out_h: 1 cycle.
- bbsy_out_h to msyn_out_h: DESKEW cycles.
- ssyn_in_h to msyn_out_h dropping: 1 cycle. msyn_out_h low to ack: ssyn-low wait plus 1 cycle.
- Timeout timer:
  - 8 bits, cleared on MSYN entry.
  - Increments each MSYN cycle and saturates at TIMEOUT.
  - With no SSYN, msyn_out_h stays high exactly TIMEOUT cycles.
- Fairness:
  - Requests that arrive simultaneously are served in ascending index order, starting after the last winner.
  - A continuously requesting index is never served twice while another index is waiting.
- ack is never asserted for two indices in the same cycle. busy=0 exactly in IDLE.

## Test plan
- Single DATI: req[0], addr 18'o001000, ctl 00; slave returns 16'o123456 → one-cycle ack[0], err=0, rdata=16'o123456, bus signals all 0 afterwards.
- DATOB: req[2], addr 18'o774401, wdata 16'o177400, ctl 11 → a_out_h=18'o774401, c_out_h=11, d_out_h=16'o177400 held from bbsy through msyn; msyn asserted DESKEW cycles after bbsy; ack[2].
- Round-robin: req[0..3] all held high → acks in order 1,2,3,0,1 with no repeats, one bus tenure per ack.
- NXM: no SSYN → msyn_out_h high exactly 200 cycles, then ack with err=1 and rdata unchanged.
- Bus contention: bbsy_in_h held high 10 cycles after npg → bbsy_out_h stays 0 until bbsy_in_h and ssyn_in_h are both low.
- init_in_h pulsed during MSYN → all outputs 0 the next cycle, no ack. The pending req is re-arbitrated after init drops.
